// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame/oversampling constants
// common to the transmitter and receiver.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both stages
// reset to 1 so a line held in reset looks idle.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 16x-oversampled 8N-with-parity frame recovery.
// Define UART_RX_PARITY_CHECK_EN to build the parity comparator.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int          OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   rx_in,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   data_valid,
    output logic                   parity_out,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   rx_busy
);

    localparam int         SAMPLE_PT  = OVERSAMPLE / 2 - 1;
    localparam logic [3:0] START_LAST = 4'(SAMPLE_PT - 1);
    localparam logic [3:0] BIT_LAST   = 4'(OVERSAMPLE - 1);

    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    uart_state_e            state;
    logic [3:0]             baud_count;
    logic [2:0]             bit_count;
    logic [UART_DATA_W-1:0] shift;
    logic                   rx_s;

    uart_rx_sync u_rx_sync (
        .sys_clk (sys_clk),
        .reset   (reset),
        .d       (rx_in),
        .q       (rx_s)
    );

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_count <= '0;
            bit_count  <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_out <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (clk_en) begin
                case (state)
                    IDLE: begin
                        baud_count <= '0;
                        if (!rx_s) begin
                            state   <= START_BIT;
                            rx_busy <= 1'b1;
                        end
                    end
                    // The detection tick is tick 0 of the start bit, so the
                    // mid-bit check falls SAMPLE_PT ticks after it.
                    START_BIT: begin
                        if (baud_count == START_LAST) begin
                            baud_count <= '0;
                            if (!rx_s) begin
                                state     <= DATA_BITS;
                                bit_count <= '0;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            baud_count <= baud_count + 4'd1;
                        end
                    end
                    DATA_BITS: begin
                        if (baud_count == BIT_LAST) begin
                            baud_count       <= '0;
                            shift[bit_count] <= rx_s;
                            bit_count        <= bit_count + 3'd1;
                            if (bit_count == 3'd7) begin
                                state <= PARITY_BIT;
                            end
                        end else begin
                            baud_count <= baud_count + 4'd1;
                        end
                    end
                    PARITY_BIT: begin
                        if (baud_count == BIT_LAST) begin
                            baud_count <= '0;
                            parity_out <= rx_s;
                            state      <= STOP_BIT;
                        end else begin
                            baud_count <= baud_count + 4'd1;
                        end
                    end
                    STOP_BIT: begin
                        if (baud_count == BIT_LAST) begin
                            baud_count <= '0;
                            data_out   <= shift;
                            frame_err  <= ~rx_s;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_CHECK_EN
                            parity_err <= ^{shift, parity_out, 1'(PARITY_ODD)};
`else
                            parity_err <= 1'b0;
`endif
                            if (rx_s) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state <= BREAK_WAIT;
                            end
                        end else begin
                            baud_count <= baud_count + 4'd1;
                        end
                    end
                    BREAK_WAIT: begin
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus break,
// false-start and mid-frame reset sequences, checked through a scoreboard.
module tb_uart_receiver;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_out;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    uart_receiver #(.OVERSAMPLE(16), .PARITY_ODD(0)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_out (parity_out),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       perr_en;   // expected parity_err when the checker is built
        logic       ferr;
    } vec_t;

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        perr;
        logic        ferr;
        int unsigned tick;
    } exp_t;

    exp_t        sbq[$];
    int          total   = 0;
    int          bad     = 0;
    int          strobes = 0;
    int unsigned tick_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // One-cycle baud tick every 4 sys_clk cycles
    initial begin
        clk_en = 1'b0;
        forever begin
            repeat (3) @(negedge sys_clk);
            clk_en = 1'b1;
            @(negedge sys_clk);
            clk_en = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            if (clk_en) tick_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard consumer
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (data_valid) begin
                strobes++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got strobe at tick %0d want none", tick_cnt);
                end else begin
                    e = sbq.pop_front();
                    check("data_out",   32'(data_out),   32'(e.data));
                    check("parity_out", 32'(parity_out), 32'(e.par));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                    check("frame_err",  32'(frame_err),  32'(e.ferr));
                    check("strobe_tick", tick_cnt,       e.tick);
                    check("busy_at_strobe", 32'(rx_busy), 32'(e.ferr));
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge sys_clk); while (!clk_en);
        end
        #1;
    endtask

    task automatic send_bits(input logic [7:0] val, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_in = val[i];
            wait_ticks(16);
        end
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        e.data = v.data;
        e.par  = v.par;
`ifdef UART_RX_PARITY_CHECK_EN
        e.perr = v.perr_en;
`else
        e.perr = 1'b0;
`endif
        e.ferr = v.ferr;
        // start detected on the next tick, stop sampled 167 ticks later
        e.tick = tick_cnt + 168;
        sbq.push_back(e);
        rx_in = 1'b0;
        wait_ticks(16);
        send_bits(v.data, 8);
        send_bits({7'd0, v.par}, 1);
        send_bits({7'd0, v.stop}, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data_out"},   32'(data_out),   32'h00);
        check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
        check({tag, "_parity_out"}, 32'(parity_out), 32'h0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
        check({tag, "_frame_err"},  32'(frame_err),  32'h0);
        check({tag, "_rx_busy"},    32'(rx_busy),    32'h0);
    endtask

    vec_t tbl[5];
    vec_t v;
    int   s0;

    initial begin
        tbl[0] = '{data: 8'hA5, par: 1'b0, stop: 1'b1, perr_en: 1'b0, ferr: 1'b0};
        tbl[1] = '{data: 8'h01, par: 1'b0, stop: 1'b1, perr_en: 1'b1, ferr: 1'b0};
        tbl[2] = '{data: 8'h00, par: 1'b0, stop: 1'b1, perr_en: 1'b0, ferr: 1'b0};
        tbl[3] = '{data: 8'hFF, par: 1'b0, stop: 1'b1, perr_en: 1'b0, ferr: 1'b0};
        tbl[4] = '{data: 8'hC3, par: 1'b1, stop: 1'b1, perr_en: 1'b1, ferr: 1'b0};

        reset = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_vals("reset");
        reset = 1'b1;
        wait_ticks(3);

        // Table frames sent back-to-back with no idle gap
        for (int i = 0; i < 5; i++) send_frame(tbl[i]);
        wait_ticks(20);
        check("table_drained", 32'(sbq.size()), 32'd0);
        check("busy_idle", 32'(rx_busy), 32'h0);

        // Framing error followed by a held break
        s0 = strobes;
        v = '{data: 8'h3C, par: 1'b0, stop: 1'b0, perr_en: 1'b0, ferr: 1'b1};
        send_frame(v);
        wait_ticks(40);
        check("break_busy", 32'(rx_busy), 32'h1);
        check("break_one_strobe", 32'(strobes - s0), 32'd1);
        rx_in = 1'b1;
        wait_ticks(4);
        check("break_release_busy", 32'(rx_busy), 32'h0);
        wait_ticks(10);

        // 4-tick glitch: false start
        s0 = strobes;
        rx_in = 1'b0;
        wait_ticks(2);
        check("glitch_busy_set", 32'(rx_busy), 32'h1);
        wait_ticks(2);
        rx_in = 1'b1;
        wait_ticks(5);
        check("glitch_busy_clear", 32'(rx_busy), 32'h0);
        wait_ticks(10);
        check("glitch_no_strobe", 32'(strobes - s0), 32'd0);
        check("glitch_data_hold", 32'(data_out), 32'h3C);
        check("glitch_ferr_hold", 32'(frame_err), 32'h1);
        v = '{data: 8'h5A, par: 1'b0, stop: 1'b1, perr_en: 1'b0, ferr: 1'b0};
        send_frame(v);
        wait_ticks(20);

        // Reset during data bit 3 of 0x81
        s0 = strobes;
        rx_in = 1'b0;
        wait_ticks(16);
        send_bits(8'h81, 3);
        rx_in = 1'b0;
        wait_ticks(8);
        check("midframe_busy", 32'(rx_busy), 32'h1);
        reset = 1'b0;
        rx_in = 1'b1;
        #1;
        check_reset_vals("midreset");
        wait_ticks(3);
        reset = 1'b1;
        wait_ticks(5);
        check("midreset_busy", 32'(rx_busy), 32'h0);
        check("midreset_no_strobe", 32'(strobes - s0), 32'd0);
        v = '{data: 8'h7E, par: 1'b0, stop: 1'b1, perr_en: 1'b0, ferr: 1'b0};
        send_frame(v);
        wait_ticks(20);

        check("final_drained", 32'(sbq.size()), 32'd0);
        check("strobe_count", 32'(strobes), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
